// File: rtl/icache_pkg.sv
// Shared geometry, address-field positions and FSM state type for the
// instruction cache controller.
package icache_pkg;

  localparam int WAYS       = 4;
  localparam int WAY_W      = 2;
  localparam int TAG_W      = 22;
  localparam int IDX_W      = 5;
  localparam int LINE_W     = 256;
  localparam int WORD_W     = 32;
  localparam int LRU_W      = 3;
  localparam int WORD_SEL_W = 3;

  // Address field positions: tag[31:10], index[9:5], word[4:2], byte[1:0].
  localparam int TAG_LSB  = 10;
  localparam int IDX_LSB  = 5;
  localparam int WORD_LSB = 2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MISS_REQ  = 2'd1,
    S_MISS_WAIT = 2'd2,
    S_REFILL    = 2'd3
  } state_e;

  // Extract one 32-bit word from a 256-bit line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0]     line,
                                                  input logic [WORD_SEL_W-1:0] sel);
    return line[{sel, 5'b00000} +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Tree pseudo-LRU for a 4-way set: picks a victim way and computes the
// updated PLRU bits after an access. Purely combinational.
//   lru[2] selects the pair (0: ways 0/1, 1: ways 2/3) to evict from,
//   lru[1] picks within ways 0/1, lru[0] picks within ways 2/3.
module icache_plru
  import icache_pkg::*;
(
  input  logic [WAYS-1:0]  valid_i,
  input  logic [LRU_W-1:0] lru_i,
  input  logic [WAY_W-1:0] upd_way_i,
  output logic [WAY_W-1:0] victim_o,
  output logic [LRU_W-1:0] lru_o
);

  // Victim: lowest-index invalid way, otherwise follow the PLRU tree.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    victim_o = lru_i[2] ? {1'b1, lru_i[0]} : {1'b0, lru_i[1]};
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_o = WAY_W'(w);
    end
  end

  // Update: point the tree away from the accessed way, keep the other subtree bit.
  always_comb begin
    lru_o = lru_i;
    unique case (upd_way_i)
      2'd0: lru_o = {1'b1, 1'b1, lru_i[0]};
      2'd1: lru_o = {1'b1, 1'b0, lru_i[0]};
      2'd2: lru_o = {1'b0, lru_i[1], 1'b1};
      2'd3: lru_o = {1'b0, lru_i[1], 1'b0};
      default: lru_o = lru_i;
    endcase
  end

endmodule

// File: rtl/icache_ctrl.sv
// 4-way, 32-set instruction cache controller. Tag/valid/LRU/data arrays
// live outside this block; it reads them asynchronously at arr_idx and
// drives their write ports. Misses fetch a full 256-bit line from memory.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  // CPU fetch port
  input  logic                   cpu_req_valid,
  input  logic [31:0]            cpu_addr,
  output logic                   cpu_ready,
  output logic                   cpu_rvalid,
  output logic [WORD_W-1:0]      cpu_rdata,
  // Line-fill memory port
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [31:0]            mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [LINE_W-1:0]      mem_resp_data,
  // Array access
  output logic [IDX_W-1:0]       arr_idx,
  output logic [TAG_W-1:0]       arr_tag,
  output logic [WAYS-1:0]        arr_wr_en,
  output logic [LINE_W-1:0]      arr_wdata,
  output logic                   lru_wr_en,
  output logic [LRU_W-1:0]       lru_wdata,
  input  logic [WAYS*TAG_W-1:0]  tag_rd,
  input  logic [WAYS-1:0]        valid_rd,
  input  logic [LRU_W-1:0]       lru_rd,
  input  logic [WAYS*LINE_W-1:0] data_rd,
  // Statistics
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
);

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;

  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    victim_way;
  logic [WAY_W-1:0]    upd_way;
  logic [LINE_W-1:0]   hit_line;

  // Byte offsets are never needed for word fetches.
  logic                unused_byte_bits;
  assign unused_byte_bits = ^{cpu_addr[1:0], addr_q[1:0]};

  icache_plru u_plru (
    .valid_i   (valid_rd),
    .lru_i     (lru_rd),
    .upd_way_i (upd_way),
    .victim_o  (victim_way),
    .lru_o     (lru_wdata)
  );

  // Tag compare for the incoming request; the lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_rd[w] && (tag_rd[w*TAG_W +: TAG_W] == cpu_addr[TAG_LSB +: TAG_W])) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line     = data_rd[{hit_way, 8'h00} +: LINE_W];
  assign mem_req_addr = {addr_q[31:IDX_LSB], 5'b00000};
  assign arr_wdata    = line_q;
  assign cpu_rvalid   = rvalid_q;
  assign cpu_rdata    = rdata_q;
  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;

  // FSM next-state, datapath next-state and array/memory strobes.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    victim_d      = victim_q;
    line_d        = line_q;
    rdata_d       = rdata_q;
    rvalid_d      = 1'b0;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    cpu_ready     = 1'b0;
    mem_req_valid = 1'b0;
    arr_wr_en     = '0;
    lru_wr_en     = 1'b0;
    upd_way       = hit_way;
    arr_idx       = addr_q[IDX_LSB +: IDX_W];
    arr_tag       = addr_q[TAG_LSB +: TAG_W];

    unique case (state_q)
      S_IDLE: begin
        cpu_ready = 1'b1;
        arr_idx   = cpu_addr[IDX_LSB +: IDX_W];
        arr_tag   = cpu_addr[TAG_LSB +: TAG_W];
        if (cpu_req_valid) begin
          if (hit) begin
            rdata_d   = line_word(hit_line, cpu_addr[WORD_LSB +: WORD_SEL_W]);
            rvalid_d  = 1'b1;
            lru_wr_en = 1'b1;
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            addr_d     = cpu_addr;
            victim_d   = victim_way;
            miss_cnt_d = miss_cnt_q + 32'd1;
            state_d    = S_MISS_REQ;
          end
        end
      end
      S_MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        if (mem_resp_valid) begin
          line_d  = mem_resp_data;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        arr_wr_en[victim_q] = 1'b1;
        lru_wr_en           = 1'b1;
        upd_way             = victim_q;
        rdata_d             = line_word(line_q, addr_q[WORD_LSB +: WORD_SEL_W]);
        rvalid_d            = 1'b1;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset must never leak a write or memory request onto the ports, even
    // while a request is being presented during reset.
    if (rst) begin
      arr_wr_en     = '0;
      lru_wr_en     = 1'b0;
      mem_req_valid = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      victim_q   <= '0;
      line_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      addr_q     <= addr_d;
      victim_q   <= victim_d;
      line_q     <= line_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: models the external tag/valid/LRU/data
// arrays and a line-fill memory, applies a table of fetches with hand-computed
// results, then walks the multi-cycle corner cases by hand.
module tb_icache_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req_valid;
  logic [31:0]   cpu_addr;
  logic          cpu_ready;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic          mem_resp_valid;
  logic [255:0]  mem_resp_data;
  logic [4:0]    arr_idx;
  logic [21:0]   arr_tag;
  logic [3:0]    arr_wr_en;
  logic [255:0]  arr_wdata;
  logic          lru_wr_en;
  logic [2:0]    lru_wdata;
  logic [87:0]   tag_rd;
  logic [3:0]    valid_rd;
  logic [2:0]    lru_rd;
  logic [1023:0] data_rd;
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_addr       (cpu_addr),
    .cpu_ready      (cpu_ready),
    .cpu_rvalid     (cpu_rvalid),
    .cpu_rdata      (cpu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .arr_idx        (arr_idx),
    .arr_tag        (arr_tag),
    .arr_wr_en      (arr_wr_en),
    .arr_wdata      (arr_wdata),
    .lru_wr_en      (lru_wr_en),
    .lru_wdata      (lru_wdata),
    .tag_rd         (tag_rd),
    .valid_rd       (valid_rd),
    .lru_rd         (lru_rd),
    .data_rd        (data_rd),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  // ---------------- external array model ----------------
  logic [21:0]  tag_m  [32][4] = '{default: '{default: '0}};
  logic [255:0] data_m [32][4] = '{default: '{default: '0}};
  logic [3:0]   val_m  [32]    = '{default: '0};
  logic [2:0]   lru_m  [32]    = '{default: '0};

  always_comb begin
    for (int w = 0; w < 4; w++) begin
      tag_rd[w*22 +: 22]   = tag_m[arr_idx][w];
      data_rd[w*256 +: 256] = data_m[arr_idx][w];
    end
    valid_rd = val_m[arr_idx];
    lru_rd   = lru_m[arr_idx];
  end

  always @(posedge clk) begin
    for (int w = 0; w < 4; w++) begin
      if (arr_wr_en[w]) begin
        tag_m[arr_idx][w]  <= arr_tag;
        data_m[arr_idx][w] <= arr_wdata;
        val_m[arr_idx][w]  <= 1'b1;
      end
    end
    if (lru_wr_en) lru_m[arr_idx] <= lru_wdata;
  end

  // ---------------- backing memory contents ----------------
  function automatic logic [31:0] mw(input logic [31:0] a);
    if (a[31:2] == 30'h12) return 32'hDEAD_BEEF;
    return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [255:0] make_line(input logic [31:0] a);
    logic [255:0] l;
    for (int n = 0; n < 8; n++) l[n*32 +: 32] = mw({a[31:5], 3'(n), 2'b00});
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // One fetch transaction, memory served inline. Caller is in the low clock
  // phase; returns in the low phase of the cycle where cpu_rvalid was seen.
  task automatic do_fetch(input  logic [31:0] a,
                          input  int          stall,
                          output bit          missed,
                          output logic [31:0] data,
                          output int          lat,
                          output logic [3:0]  wr,
                          output logic [2:0]  lru_w,
                          output bit          ok);
    int stalled;
    bit hs, sent;
    missed = 0; data = '0; lat = 0; wr = '0; lru_w = '0; ok = 0;
    stalled = 0; hs = 0; sent = 0;
    cpu_req_valid = 1'b1;
    cpu_addr      = a;
    #1;
    if (lru_wr_en) lru_w = lru_wdata;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    #1;
    for (int k = 1; k <= 60; k++) begin
      if (arr_wr_en != 4'b0) wr = arr_wr_en;
      if (lru_wr_en) lru_w = lru_wdata;
      if (cpu_rvalid) begin
        data = cpu_rdata;
        lat  = k;
        ok   = 1;
        break;
      end
      mem_resp_valid = 1'b0;
      if (mem_req_valid) begin
        missed = 1;
        check($sformatf("mem_req_addr_%h", a), mem_req_addr, {a[31:5], 5'b00000});
        check($sformatf("cpu_ready_busy_%h", a), 32'(cpu_ready), 32'd0);
        if (stalled < stall) begin
          stalled++;
          mem_req_ready = 1'b0;
        end else begin
          mem_req_ready = 1'b1;
          hs = 1;
        end
      end else begin
        mem_req_ready = 1'b0;
        if (hs && !sent) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = make_line(a);
          sent = 1;
        end
      end
      @(negedge clk);
      #1;
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    logic [31:0] data;
    logic [3:0]  wr;
    logic [2:0]  lru;
    int          hits;
    int          misses;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input bit m, input logic [31:0] d,
                              input logic [3:0] w, input logic [2:0] l, input int h, input int ms);
    vec_t v;
    v.addr = a; v.miss = m; v.data = d; v.wr = w; v.lru = l; v.hits = h; v.misses = ms;
    return v;
  endfunction

  vec_t vecs [11];

  initial begin
    bit          missed, ok;
    logic [31:0] data;
    int          lat;
    logic [3:0]  wr;
    logic [2:0]  lru_w;

    // Set 2 line at 0x40, then set 3 filled way0..way3 and overflowed.
    vecs[0]  = mk(32'h0000_0040, 1, mw(32'h0000_0040), 4'b0001, 3'b110, 0, 1);
    vecs[1]  = mk(32'h0000_0048, 0, 32'hDEAD_BEEF,     4'b0000, 3'b110, 1, 1);
    vecs[2]  = mk(32'h0000_0044, 0, mw(32'h0000_0044), 4'b0000, 3'b110, 2, 1);
    vecs[3]  = mk(32'h0000_0060, 1, mw(32'h0000_0060), 4'b0001, 3'b110, 2, 2);
    vecs[4]  = mk(32'h0000_0460, 1, mw(32'h0000_0460), 4'b0010, 3'b100, 2, 3);
    vecs[5]  = mk(32'h0000_0860, 1, mw(32'h0000_0860), 4'b0100, 3'b001, 2, 4);
    vecs[6]  = mk(32'h0000_0C60, 1, mw(32'h0000_0C60), 4'b1000, 3'b000, 2, 5);
    vecs[7]  = mk(32'h0000_1060, 1, mw(32'h0000_1060), 4'b0001, 3'b110, 2, 6);
    vecs[8]  = mk(32'h0000_0464, 0, mw(32'h0000_0464), 4'b0000, 3'b100, 3, 6);
    vecs[9]  = mk(32'h0000_0060, 1, mw(32'h0000_0060), 4'b0100, 3'b001, 3, 7);
    vecs[10] = mk(32'h0000_1068, 0, mw(32'h0000_1068), 4'b0000, 3'b111, 4, 7);

    rst            = 1'b1;
    cpu_req_valid  = 1'b0;
    cpu_addr       = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
    check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_arr_wr_en", 32'(arr_wr_en), 32'd0);
    check("rst_lru_wr_en", 32'(lru_wr_en), 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b0;

    // Table-driven fetches
    for (int i = 0; i < 11; i++) begin
      do_fetch(vecs[i].addr, 0, missed, data, lat, wr, lru_w, ok);
      check($sformatf("v%0d_done", i), 32'(ok), 32'd1);
      check($sformatf("v%0d_miss", i), 32'(missed), 32'(vecs[i].miss));
      check($sformatf("v%0d_data", i), data, vecs[i].data);
      if (!vecs[i].miss) check($sformatf("v%0d_hit_latency", i), 32'(lat), 32'd1);
      check($sformatf("v%0d_arr_wr_en", i), 32'(wr), 32'(vecs[i].wr));
      check($sformatf("v%0d_lru_wdata", i), 32'(lru_w), 32'(vecs[i].lru));
      check($sformatf("v%0d_hit_cnt", i), hit_cnt, 32'(vecs[i].hits));
      check($sformatf("v%0d_miss_cnt", i), miss_cnt, 32'(vecs[i].misses));
    end

    // cpu_rvalid is a single-cycle pulse
    @(negedge clk); #1;
    check("rvalid_pulse", 32'(cpu_rvalid), 32'd0);

    // Memory holds off the request for 10 cycles; address must stay aligned/stable
    do_fetch(32'h0000_2014, 10, missed, data, lat, wr, lru_w, ok);
    check("stall_done", 32'(ok), 32'd1);
    check("stall_miss", 32'(missed), 32'd1);
    check("stall_data", data, mw(32'h0000_2014));
    check("stall_wr", 32'(wr), 32'b0001);
    check("stall_lru", 32'(lru_w), 32'b110);
    check("stall_miss_cnt", miss_cnt, 32'd8);

    // Spurious memory response while idle is ignored
    mem_resp_valid = 1'b1;
    mem_resp_data  = {8{32'h5555_AAAA}};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check($sformatf("spurious_wr_%0d", k), 32'(arr_wr_en), 32'd0);
      check($sformatf("spurious_ready_%0d", k), 32'(cpu_ready), 32'd1);
    end
    mem_resp_valid = 1'b0;
    do_fetch(32'h0000_2014, 0, missed, data, lat, wr, lru_w, ok);
    check("spurious_after_miss", 32'(missed), 32'd0);
    check("spurious_after_data", data, mw(32'h0000_2014));
    check("spurious_after_hit_cnt", hit_cnt, 32'd5);

    // Reset in MISS_WAIT aborts the fill
    @(negedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_addr      = 32'h0000_3000;
    @(negedge clk); #1;
    cpu_req_valid = 1'b0;
    check("abort_req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk); #1;
    mem_req_ready = 1'b0;
    check("abort_in_wait", 32'(mem_req_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(cpu_ready), 32'd1);
    check("abort_hit_cnt", hit_cnt, 32'd0);
    check("abort_miss_cnt", miss_cnt, 32'd0);
    check("abort_rvalid", 32'(cpu_rvalid), 32'd0);
    check("abort_rdata", cpu_rdata, 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = make_line(32'h0000_3000);
    @(negedge clk); #1;
    check("abort_wr_in_rst", 32'(arr_wr_en), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("abort_wr_after_rst", 32'(arr_wr_en), 32'd0);
    check("abort_idle_after_rst", 32'(cpu_ready), 32'd1);
    mem_resp_valid = 1'b0;
    @(negedge clk); #1;
    check("abort_no_wr_later", 32'(arr_wr_en), 32'd0);

    // The aborted line was never written: it misses again into way1
    do_fetch(32'h0000_3000, 0, missed, data, lat, wr, lru_w, ok);
    check("refetch_miss", 32'(missed), 32'd1);
    check("refetch_data", data, mw(32'h0000_3000));
    check("refetch_wr", 32'(wr), 32'b0010);
    check("refetch_lru", 32'(lru_w), 32'b100);
    check("refetch_miss_cnt", miss_cnt, 32'd1);
    do_fetch(32'h0000_2018, 0, missed, data, lat, wr, lru_w, ok);
    check("post_rst_hit", 32'(missed), 32'd0);
    check("post_rst_data", data, mw(32'h0000_2018));
    check("post_rst_hit_cnt", hit_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
